// File: rtl/jtkunio_gfx_arb.sv
// Round-robin arbiter sharing one SDRAM read port between the char, scroll and
// object ROM fetchers. Optional watchdog abort enabled by JTKUNIO_ARB_TIMEOUT_EN.
module jtkunio_gfx_arb #(
  parameter logic [19:0] CHAR_OFFSET = 20'h00000,
  parameter logic [19:0] SCR_OFFSET  = 20'h04000,
  parameter logic [19:0] OBJ_OFFSET  = 20'h24000,
  parameter logic [7:0]  TOUT        = 8'd63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        char_cs,
  input  logic [13:0] char_addr,
  output logic [31:0] char_data,
  output logic        char_ok,
  input  logic        scr_cs,
  input  logic [16:0] scr_addr,
  output logic [31:0] scr_data,
  output logic        scr_ok,
  input  logic        obj_cs,
  input  logic [17:0] obj_addr,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  output logic        sdram_req,
  output logic [19:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic [31:0] sdram_data,
`ifdef JTKUNIO_ARB_TIMEOUT_EN
  output logic        tout_flag,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, next_state;
  logic [2:0]  valid, hit, pend;
  logic [13:0] char_tag;
  logic [16:0] scr_tag;
  logic [17:0] obj_tag;
  logic [17:0] iss_addr, grant_addr;
  logic [19:0] grant_sdram;
  logic [1:0]  sel, rr, grant;
  logic        fill, abort;

  assign hit[0] = valid[0] && (char_tag == char_addr);
  assign hit[1] = valid[1] && (scr_tag  == scr_addr);
  assign hit[2] = valid[2] && (obj_tag  == obj_addr);
  assign pend   = {obj_cs && !hit[2], scr_cs && !hit[1], char_cs && !hit[0]};
  assign fill   = ((state == REQ) && sdram_ack && sdram_dst) || ((state == WAIT) && sdram_dst);
  assign busy   = (state != IDLE);

`ifdef JTKUNIO_ARB_TIMEOUT_EN
  logic [7:0] wd;

  assign abort = (state != IDLE) && (wd == TOUT) && !fill;

  // Watchdog: restarts on every issue, counts while a request is outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd        <= 8'd0;
      tout_flag <= 1'b0;
    end else begin
      if (state == IDLE) begin
        wd <= 8'd0;
      end else begin
        wd <= wd + 8'd1;
      end
      if (abort) begin
        tout_flag <= 1'b1;
      end
    end
  end
`else
  logic unused_tout;
  assign unused_tout = ^TOUT;
  assign abort       = 1'b0;
`endif

  // Round-robin pick: search starts at rr and wraps char -> scr -> obj
  always_comb begin
    grant = rr;
    case (rr)
      2'd0:    grant = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
      2'd1:    grant = pend[1] ? 2'd1 : (pend[2] ? 2'd2 : 2'd0);
      2'd2:    grant = pend[2] ? 2'd2 : (pend[0] ? 2'd0 : 2'd1);
      default: grant = 2'd0;
    endcase
    grant_addr  = 18'd0;
    grant_sdram = 20'd0;
    case (grant)
      2'd0: begin
        grant_addr  = {4'd0, char_addr};
        grant_sdram = CHAR_OFFSET + {6'd0, char_addr};
      end
      2'd1: begin
        grant_addr  = {1'd0, scr_addr};
        grant_sdram = SCR_OFFSET + {3'd0, scr_addr};
      end
      2'd2: begin
        grant_addr  = obj_addr;
        grant_sdram = OBJ_OFFSET + {2'd0, obj_addr};
      end
      default: begin
        grant_addr  = 18'd0;
        grant_sdram = 20'd0;
      end
    endcase
  end

  // Next-state logic; ack together with dst collapses REQ straight to IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (|pend) next_state = REQ;
        else       next_state = IDLE;
      end
      REQ: begin
        if (fill || abort)  next_state = IDLE;
        else if (sdram_ack) next_state = WAIT;
        else                next_state = REQ;
      end
      WAIT: begin
        if (fill || abort) next_state = IDLE;
        else               next_state = WAIT;
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Request issue, cache fill, round-robin pointer and registered ok flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdram_req  <= 1'b0;
      sdram_addr <= 20'd0;
      sel        <= 2'd0;
      rr         <= 2'd0;
      iss_addr   <= 18'd0;
      valid      <= 3'd0;
      char_tag   <= 14'd0;
      scr_tag    <= 17'd0;
      obj_tag    <= 18'd0;
      char_data  <= 32'd0;
      scr_data   <= 32'd0;
      obj_data   <= 32'd0;
      char_ok    <= 1'b0;
      scr_ok     <= 1'b0;
      obj_ok     <= 1'b0;
    end else begin
      char_ok <= char_cs && hit[0];
      scr_ok  <= scr_cs  && hit[1];
      obj_ok  <= obj_cs  && hit[2];
      if ((state == IDLE) && (|pend)) begin
        sel        <= grant;
        iss_addr   <= grant_addr;
        sdram_addr <= grant_sdram;
        sdram_req  <= 1'b1;
      end else if (((state == REQ) && sdram_ack) || abort) begin
        sdram_req  <= 1'b0;
      end
      if (fill) begin
        case (sel)
          2'd0: begin valid[0] <= 1'b1; char_tag <= iss_addr[13:0]; char_data <= sdram_data; end
          2'd1: begin valid[1] <= 1'b1; scr_tag  <= iss_addr[16:0]; scr_data  <= sdram_data; end
          2'd2: begin valid[2] <= 1'b1; obj_tag  <= iss_addr;       obj_data  <= sdram_data; end
          default: valid <= valid;
        endcase
      end
      // An aborted fetch also moves the pointer on so others get a turn first
      if (fill || abort) begin
        rr <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
      end
    end
  end

endmodule
